// File: rtl/ir_pkg.sv
// Shared definitions for the IR key event controller: event-type codes,
// FSM state encoding and the FIFO entry layout.
package ir_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_REPEAT  = 2'b01,
        EVT_RELEASE = 2'b10
    } ir_evt_type_t;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_HELD       = 2'd1,
        S_PRESS_PEND = 2'd2
    } ir_state_t;

    // One FIFO entry: {type, cmd}, 10 bits
    typedef struct packed {
        logic [1:0] typ;
        logic [7:0] cmd;
    } ir_evt_t;

    localparam int unsigned EVT_W = 10;

    // Bits needed to hold values 0..term; never less than one bit
    function automatic int unsigned cnt_width(input int unsigned term);
        return (term < 2) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// First-word fall-through event FIFO. Simultaneous push and pop are always
// accepted (even when full); a push into a full FIFO without a pop is
// dropped and reported by a one-cycle overflow pulse.
module ir_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign do_push = push & (~full | do_pop);

    // Head entry, forced to zero when nothing is queued
    assign dout = empty ? '0 : mem[rd_ptr];

    // Pointer, occupancy and overflow-pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & ~do_push;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ir_key_evt_ctrl.sv
// Turns decoded NEC codes into PRESS / REPEAT / RELEASE key events.
// A key is considered held until a different code arrives or no matching
// code is seen for HOLD_TIMEOUT_MS; events are queued in ir_evt_fifo.
module ir_key_evt_ctrl
    import ir_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter logic [7:0]  DEV_ADDR        = 8'h00,
    parameter bit          ADDR_FILTER_EN  = 1'b1,
    parameter int unsigned HOLD_TIMEOUT_MS = 120,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] ir_code,
    input  logic        ir_code_valid,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [7:0]  evt_cmd,
    output logic [1:0]  evt_type,
    output logic        overflow
);

    localparam int unsigned TERM = HOLD_TIMEOUT_MS * (CLK_FREQ / 1000) - 1;
    localparam int unsigned TW   = cnt_width(TERM);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

    ir_state_t     state;
    ir_state_t     state_nxt;
    logic [7:0]    held_cmd;
    logic [7:0]    held_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          accepted;
    logic [7:0]    strobe_cmd;
    logic          push;
    ir_evt_t       push_evt;
    ir_evt_t       head_evt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign strobe_cmd = ir_code[7:0];
    assign accepted   = ir_code_valid &
                        (~ADDR_FILTER_EN | (ir_code[15:8] == DEV_ADDR));

    // FSM, held command and hold timer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            held_cmd <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            held_cmd <= held_nxt;
            timer    <= timer_nxt;
        end
    end

    // Next-state, timer and event-push decode; a strobe beats timer expiry
    always_comb begin
        state_nxt    = state;
        held_nxt     = held_cmd;
        timer_nxt    = timer;
        push         = 1'b0;
        push_evt.typ = EVT_PRESS;
        push_evt.cmd = held_cmd;
        case (state)
            S_IDLE: begin
                if (accepted) begin
                    push         = 1'b1;
                    push_evt.typ = EVT_PRESS;
                    push_evt.cmd = strobe_cmd;
                    held_nxt     = strobe_cmd;
                    timer_nxt    = '0;
                    state_nxt    = S_HELD;
                end
            end
            S_HELD: begin
                if (accepted) begin
                    push      = 1'b1;
                    timer_nxt = '0;
                    if (strobe_cmd == held_cmd) begin
                        push_evt.typ = EVT_REPEAT;
                        push_evt.cmd = strobe_cmd;
                    end else begin
                        push_evt.typ = EVT_RELEASE;
                        push_evt.cmd = held_cmd;
                        held_nxt     = strobe_cmd;
                        state_nxt    = S_PRESS_PEND;
                    end
                end else if (timer == TW'(TERM)) begin
                    push         = 1'b1;
                    push_evt.typ = EVT_RELEASE;
                    push_evt.cmd = held_cmd;
                    timer_nxt    = '0;
                    state_nxt    = S_IDLE;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            S_PRESS_PEND: begin
                push         = 1'b1;
                push_evt.typ = EVT_PRESS;
                push_evt.cmd = held_cmd;
                timer_nxt    = '0;
                state_nxt    = S_HELD;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    ir_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (push_evt),
        .pop      (evt_ready),
        .dout     (head_evt),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .overflow (overflow)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_cmd   = head_evt.cmd;
    assign evt_type  = head_evt.typ;

    // FIFO full flag must agree with its occupancy counter
    a_full_count: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ir_key_evt_ctrl.sv
// Bench for ir_key_evt_ctrl: two instances (address filter on / off) driven
// by the same stimulus and compared every cycle against a queue-based model
// of the key-event rules.
module tb_ir_key_evt_ctrl;

    localparam int unsigned TO    = 2000;  // 2 ms at 1 MHz
    localparam int unsigned DEPTH = 4;
    localparam logic [1:0]  T_PRESS   = 2'b00;
    localparam logic [1:0]  T_REPEAT  = 2'b01;
    localparam logic [1:0]  T_RELEASE = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] code;
    logic        code_valid;
    logic        ready;

    logic       v0, v1, o0, o1;
    logic [7:0] c0, c1;
    logic [1:0] t0, t1;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned ovf_seen = 0;

    // Model state per instance (0: filter on, 1: filter off)
    bit          m_hold [2];
    bit          m_pend [2];
    logic [7:0]  m_held [2];
    int unsigned m_age  [2];
    logic [9:0]  m_q    [2][DEPTH];
    int unsigned m_head [2];
    int unsigned m_n    [2];
    bit          m_ovf  [2];

    always #5 clk = ~clk;

    ir_key_evt_ctrl #(
        .CLK_FREQ        (1_000_000),
        .DEV_ADDR        (8'h00),
        .ADDR_FILTER_EN  (1'b1),
        .HOLD_TIMEOUT_MS (2),
        .FIFO_DEPTH      (DEPTH)
    ) u_flt (
        .clk           (clk),
        .rst_n         (rst_n),
        .ir_code       (code),
        .ir_code_valid (code_valid),
        .evt_valid     (v0),
        .evt_ready     (ready),
        .evt_cmd       (c0),
        .evt_type      (t0),
        .overflow      (o0)
    );

    ir_key_evt_ctrl #(
        .CLK_FREQ        (1_000_000),
        .DEV_ADDR        (8'h00),
        .ADDR_FILTER_EN  (1'b0),
        .HOLD_TIMEOUT_MS (2),
        .FIFO_DEPTH      (DEPTH)
    ) u_all (
        .clk           (clk),
        .rst_n         (rst_n),
        .ir_code       (code),
        .ir_code_valid (code_valid),
        .evt_valid     (v1),
        .evt_ready     (ready),
        .evt_cmd       (c1),
        .evt_type      (t1),
        .overflow      (o1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic mdl_push(input int i, input logic [1:0] typ, input logic [7:0] cmd);
        if (m_n[i] < DEPTH) begin
            m_q[i][(m_head[i] + m_n[i]) % DEPTH] = {typ, cmd};
            m_n[i]++;
        end else begin
            m_ovf[i] = 1'b1;
        end
    endtask

    // Apply one clock edge of the key rules to the model of instance i
    task automatic mdl_step(input int i);
        bit acc;
        if (!rst_n) begin
            m_hold[i] = 0; m_pend[i] = 0; m_held[i] = '0; m_age[i] = 0;
            m_head[i] = 0; m_n[i] = 0; m_ovf[i] = 0;
            return;
        end
        m_ovf[i] = 0;
        if (ready && m_n[i] > 0) begin
            m_head[i] = (m_head[i] + 1) % DEPTH;
            m_n[i]--;
        end
        acc = code_valid && (i == 1 || code[15:8] == 8'h00);
        if (m_pend[i]) begin
            mdl_push(i, T_PRESS, m_held[i]);
            m_pend[i] = 0; m_hold[i] = 1; m_age[i] = 0;
        end else if (!m_hold[i]) begin
            if (acc) begin
                mdl_push(i, T_PRESS, code[7:0]);
                m_held[i] = code[7:0]; m_hold[i] = 1; m_age[i] = 0;
            end
        end else if (acc) begin
            if (code[7:0] == m_held[i]) begin
                mdl_push(i, T_REPEAT, code[7:0]);
                m_age[i] = 0;
            end else begin
                mdl_push(i, T_RELEASE, m_held[i]);
                m_held[i] = code[7:0]; m_hold[i] = 0; m_pend[i] = 1;
            end
        end else if (m_age[i] + 1 == TO) begin
            mdl_push(i, T_RELEASE, m_held[i]);
            m_hold[i] = 0; m_age[i] = 0;
        end else begin
            m_age[i]++;
        end
    endtask

    task automatic cmp_one(input int i, input logic v, input logic [7:0] c,
                           input logic [1:0] t, input logic o);
        logic [9:0] h;
        h = m_q[i][m_head[i]];
        chk(i == 0 ? "flt.valid" : "all.valid", {31'd0, v}, {31'd0, m_n[i] > 0});
        if (m_n[i] > 0) begin
            chk(i == 0 ? "flt.cmd"  : "all.cmd",  {24'd0, c}, {24'd0, h[7:0]});
            chk(i == 0 ? "flt.type" : "all.type", {30'd0, t}, {30'd0, h[9:8]});
        end
        chk(i == 0 ? "flt.ovf" : "all.ovf", {31'd0, o}, {31'd0, m_ovf[i]});
    endtask

    // One clock: drive inputs, advance the model, check both instances
    task automatic cyc(input bit v, input logic [15:0] c, input bit r, input bit rn);
        code_valid = v;
        code       = c;
        ready      = r;
        rst_n      = rn;
        mdl_step(0);
        mdl_step(1);
        @(posedge clk);
        @(negedge clk);
        if (o0) ovf_seen++;
        cmp_one(0, v0, c0, t0, o0);
        cmp_one(1, v1, c1, t1, o1);
    endtask

    task automatic idle(input int n, input bit r);
        for (int k = 0; k < n; k++) cyc(1'b0, 16'h0000, r, 1'b1);
    endtask

    initial begin
        // Reset
        for (int k = 0; k < 3; k++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("rst.valid", {31'd0, v0}, 32'd0);
        chk("rst.cmd",   {24'd0, c0}, 32'd0);
        chk("rst.type",  {30'd0, t0}, 32'd0);

        // Single press, timeout release
        cyc(1'b1, 16'h0045, 1'b1, 1'b1);
        idle(TO + 5, 1'b1);

        // Press then two repeats, release after the last
        cyc(1'b1, 16'h0045, 1'b1, 1'b1);
        idle(1499, 1'b1);
        cyc(1'b1, 16'h0045, 1'b1, 1'b1);
        idle(1499, 1'b1);
        cyc(1'b1, 16'h0045, 1'b1, 1'b1);
        idle(TO + 5, 1'b1);

        // Key change: RELEASE old then PRESS new on consecutive cycles
        cyc(1'b1, 16'h0045, 1'b1, 1'b1);
        idle(10, 1'b1);
        cyc(1'b1, 16'h0046, 1'b1, 1'b1);
        cyc(1'b1, 16'h0046, 1'b1, 1'b1);  // lands in the pending-press cycle
        idle(TO + 5, 1'b1);

        // Foreign address: dropped by the filtered instance only
        cyc(1'b1, 16'h0145, 1'b1, 1'b1);
        idle(TO + 5, 1'b1);

        // Back-pressure: six strobes into a 4-deep FIFO
        ovf_seen = 0;
        for (int k = 0; k < 6; k++) cyc(1'b1, 16'h0045, 1'b0, 1'b1);
        chk("bp.ovf_pulses", ovf_seen, 32'd2);
        chk("bp.full_valid", {31'd0, v0}, 32'd1);
        idle(6, 1'b1);
        idle(TO + 5, 1'b1);

        // Reset mid-hold with events queued: all discarded, no RELEASE
        cyc(1'b1, 16'h0045, 1'b0, 1'b1);
        cyc(1'b1, 16'h0045, 1'b0, 1'b1);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("midrst.valid", {31'd0, v0}, 32'd0);
        idle(TO + 100, 1'b1);

        // Randomized phases with varying strobe density
        for (int ph = 0; ph < 4; ph++) begin
            int unsigned dens;
            dens = (ph == 0) ? 8 : (ph == 1) ? 30 : (ph == 2) ? 300 : 2500;
            for (int k = 0; k < 1500; k++) begin
                bit         rv, rr, rrn;
                logic [7:0] a, cm;
                rv  = ($urandom_range(dens - 1, 0) == 0);
                a   = ($urandom_range(3, 0) == 0) ? 8'h01 : 8'h00;
                cm  = 8'h44 + 8'($urandom_range(2, 0));
                rr  = ($urandom_range(3, 0) != 0);
                rrn = ($urandom_range(999, 0) != 0);
                cyc(rv, {a, cm}, rr, rrn);
            end
        end
        idle(TO + 10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
